// File: rtl/seq_demux_pkg.sv
// Shared constants and helpers for the seq_demux distribution block.
//   NUM_OUT : number of output lanes (must be <= 2**SEL_W)
//   WIDTH   : data width per lane
//   SEL_W   : lane-select width
//   DROP_W  : width of the saturating drop counter
package seq_demux_pkg;

    localparam int unsigned NUM_OUT = 31;
    localparam int unsigned WIDTH   = 2;
    localparam int unsigned SEL_W   = 5;
    localparam int unsigned DROP_W  = 8;

    // True when sel names an existing lane; anything else is consumed as a drop.
    function automatic logic lane_in_range(input logic [31:0] sel, input int unsigned num_out);
        return sel < num_out;
    endfunction

endpackage

// File: rtl/demux_lane_slot.sv
// One-entry holding slot for a single demux output lane.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   load        : write load_data into the slot this cycle
//   load_data   : word to store
//   out_valid   : slot holds a word
//   out_ready   : downstream consumer ready
//   out_data    : stored word (holds last value while empty)
//   can_load    : slot is empty or being drained this cycle
module demux_lane_slot
    import seq_demux_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             can_load
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            // A fill wins over a simultaneous drain, so the slot streams without bubbles.
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign can_load  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule

// File: rtl/seq_demux.sv
// Registered 1-to-NUM_OUT demultiplexer with valid/ready handshakes.
// Each accepted word is routed to a one-entry slot on the lane named by in_sel;
// selects with no matching lane are accepted, discarded and counted.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   in_valid   : input word valid
//   in_ready   : input word can be accepted this cycle (independent of in_valid)
//   in_sel     : destination lane index
//   in_data    : data word
//   out_valid  : per-lane slot full, bit i is lane i
//   out_ready  : per-lane consumer ready
//   out_data   : lane i at bits [i*WIDTH +: WIDTH]
//   drop_cnt   : saturating count of out-of-range words
module seq_demux
    import seq_demux_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [WIDTH-1:0]         in_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [DROP_W-1:0]        drop_cnt
);

    logic [NUM_OUT-1:0] w_can_load;
    logic [NUM_OUT-1:0] w_load;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_in_range;
    logic               w_drop;
    logic [DROP_W-1:0]  r_drop_cnt;

    assign w_in_range = lane_in_range(32'(in_sel), NUM_OUT);

    // Out-of-range selects are always ready so the producer is never blocked on them.
    always_comb begin
        w_in_ready = 1'b1;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (in_sel == SEL_W'(i)) begin
                w_in_ready = w_can_load[i];
            end
        end
    end

    assign in_ready = w_in_ready;
    assign w_accept = in_valid && w_in_ready;
    assign w_drop   = w_accept && !w_in_range;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
        assign w_load[i] = w_accept && (in_sel == SEL_W'(i));

        demux_lane_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (w_load[i]),
            .load_data (in_data),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH]),
            .can_load  (w_can_load[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;

endmodule
